// File: rtl/spi_flash_resp.sv
// spi_flash_resp: SPI mode-0 responder emulating the read side of a serial NOR flash
// (READ 0x03, RDID 0x9F, RDSR 0x05), with SPI inputs synchronised into the clk domain.
module spi_flash_resp #(
  parameter int          ADDR_W = 16,
  parameter logic [7:0]  MFG_ID = 8'hEF,
  parameter logic [15:0] DEV_ID = 16'h4016,
  parameter logic [7:0]  STATUS = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk_i,
  input  logic              spi_mosi_i,
  input  logic              spi_cs0_i,
  output logic              spi_miso_o,
  output logic              spi_oe_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              active_o
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGN} state_t;
  state_t state_q;
  logic [2:0] sclk_sync_q;
  logic [1:0] mosi_sync_q, cs_sync_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_sr_q;
  logic [7:0] tx_sr_q, rdata_q;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [1:0] abyte_q, idx_q;
  logic load_q, mem_rd_q, rd_d1_q, oe_q, active_q;
  logic rise, fall, cs_low, byte_done;
  logic [7:0] rx_d, id_byte, resp_d;
  assign rise      = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall      = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_low    = ~cs_sync_q[1];
  assign rx_d      = {rx_sr_q, mosi_sync_q[1]};
  assign byte_done = rise & (bit_cnt_q == 3'd7);
  assign id_byte   = idx_q == 2'd0 ? MFG_ID : idx_q == 2'd1 ? DEV_ID[15:8] :
                     idx_q == 2'd2 ? DEV_ID[7:0] : 8'hFF;
  assign resp_d    = state_q == DATA ? rdata_q : state_q == ID ? id_byte :
                     state_q == STAT ? STATUS : 8'hFF;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= 2'b11;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= 8'hFF;
      rdata_q     <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      abyte_q     <= '0;
      idx_q       <= '0;
      load_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      rd_d1_q     <= 1'b0;
      oe_q        <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      cs_sync_q   <= {cs_sync_q[0], spi_cs0_i};
      mem_rd_q    <= 1'b0;
      rd_d1_q     <= mem_rd_q;
      oe_q        <= cs_low;
      if (rd_d1_q) rdata_q <= mem_rdata_i;
      if (!cs_low || state_q == IDLE) begin
        // CS high wins over any same-cycle SCLK edge and discards a partial byte
        state_q   <= cs_low ? CMD : IDLE;
        active_q  <= cs_low;
        bit_cnt_q <= '0;
        tx_sr_q   <= 8'hFF;
        load_q    <= 1'b0;
      end else begin
        if (rise) begin
          rx_sr_q   <= rx_d[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          load_q    <= byte_done;
        end
        if (fall) begin
          tx_sr_q <= load_q ? resp_d : {tx_sr_q[6:0], 1'b1};
          if (load_q && state_q == ID && idx_q != 2'd3) idx_q <= idx_q + 2'd1;
        end
        if (byte_done) begin
          case (state_q)
            CMD: begin
              state_q <= rx_d == 8'h03 ? ADDR : rx_d == 8'h9F ? ID : rx_d == 8'h05 ? STAT : IGN;
              abyte_q <= '0;
              idx_q   <= '0;
            end
            ADDR: begin
              addr_q  <= ADDR_W'({addr_q, rx_d});
              abyte_q <= abyte_q + 2'd1;
              if (abyte_q == 2'd2) begin
                mem_addr_q <= ADDR_W'({addr_q, rx_d});
                mem_rd_q   <= 1'b1;
                state_q    <= DATA;
              end
            end
            DATA: begin
              mem_addr_q <= mem_addr_q + 1'b1;
              mem_rd_q   <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end
  assign spi_miso_o = tx_sr_q[7];
  assign spi_oe_o   = oe_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = mem_addr_q;
  assign active_o   = active_q;
endmodule
